wbm_cmd_master: RTL and testbench

- Wishbone bus initiator for the monitor's 16-bit address / 16-bit data Wishbone fabric.
- Accepts single read/write commands on a valid/ready stream and runs one classic Wishbone cycle per command.
- Returns the read data and an error flag on a valid/ready response stream.
- Sits between a command source (serial/debug front end) and slaves on the fabric, such as the GPIO controller and the other register blocks.

---
 rtl/wbm_pkg.sv | 13 +
 rtl/wbm_timeout_ctr.sv | 38 +++
 rtl/wbm_cmd_master.sv | 174 +++++++++++++++++
 tb/tb_wbm_cmd_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbm_pkg.sv
// rtl/wbm_pkg.sv - shared widths and state encoding for the Wishbone command master
package wbm_pkg;

  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// rtl/wbm_timeout_ctr.sv - bus-wait cycle counter with expiry pulse (used only with WBM_TIMEOUT_EN)
module wbm_timeout_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] cnt_inc;

  // The count after this cycle; expiry fires on the edge that would reach the limit.
  assign cnt_inc = cnt_q + 16'd1;
  assign expired = enable && (cnt_inc == limit);

  // Next count: restart on a new command, advance while waiting on the bus.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_inc;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wbm_cmd_master.sv
// rtl/wbm_cmd_master.sv - single-command Wishbone initiator; bus timeout enabled by WBM_TIMEOUT_EN
module wbm_cmd_master
  import wbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [WB_ADR_W-1:0]  cmd_adr,
  input  logic [WB_DAT_W-1:0]  cmd_dat,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WB_DAT_W-1:0]  rsp_dat,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [WB_ADR_W-1:0]  wb_adr_o,
  output logic [WB_DAT_W-1:0]  wb_dat_o,
  input  logic [WB_DAT_W-1:0]  wb_dat_i,
  input  logic                 wb_ack_i
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  wbm_state_t            state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WB_DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [WB_ADR_W-1:0]   adr_q, adr_d;
  logic [WB_DAT_W-1:0]   dat_q, dat_d;
  logic                  accept;
  logic                  tmo_expired;

  assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;

`ifdef WBM_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic                  rsp_err_q, rsp_err_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  wbm_timeout_ctr u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (accept),
    .enable  (state_q == BUS),
    .limit   (TMO_LIMIT),
    .expired (tmo_expired)
  );

  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;
`else
  assign tmo_expired = 1'b0;
  assign rsp_err     = 1'b0;
  assign err_count   = '0;
`endif

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
`ifdef WBM_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = BUS;
        end
      end
      BUS: begin
        // A same-edge ack beats the timeout.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wb_dat_i;
          rsp_valid_d = 1'b1;
`ifdef WBM_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RESP;
        end else if (tmo_expired) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_valid_d = 1'b1;
`ifdef WBM_TIMEOUT_EN
          rsp_err_d   = 1'b1;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
          end
`endif
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any command or response in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
`ifdef WBM_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
`ifdef WBM_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_wbm_cmd_master.sv
// tb/tb_wbm_cmd_master.sv - self-checking bench for wbm_cmd_master (timeout cases under WBM_TIMEOUT_EN)
module tb_wbm_cmd_master;

  localparam int TB_TMO = 4;
  localparam int TB_ECW = 8;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [15:0]       cmd_adr = '0;
  logic [15:0]       cmd_dat = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [15:0]       rsp_dat;
  logic              rsp_err;
  logic [TB_ECW-1:0] err_count;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0]       wb_adr_o, wb_dat_o;
  logic [15:0]       wb_dat_i;
  logic              wb_ack_i;

  wbm_cmd_master #(.TIMEOUT_CYCLES(TB_TMO), .ERR_CNT_W(TB_ECW)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr  (cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err  (rsp_err), .err_count(err_count),
    .wb_cyc_o (wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o (wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Register-file slave: registered ack raised after slave_wait extra cycles of stb.
  logic [15:0] mem [0:255] = '{default: 16'h0000};
  logic        slave_en   = 1'b1;
  int          slave_wait = 0;
  int          wcnt       = 0;
  logic        slave_ack  = 1'b0;
  logic [15:0] slave_dat  = '0;
  logic        stray_ack  = 1'b0;

  assign wb_ack_i = slave_ack | stray_ack;
  assign wb_dat_i = slave_dat;

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      slave_ack <= 1'b0;
      wcnt      <= 0;
    end else begin
      slave_ack <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !slave_ack && slave_en) begin
        if (wcnt == slave_wait) begin
          slave_ack <= 1'b1;
          wcnt      <= 0;
          if (wb_we_o) mem[wb_adr_o[7:0]] <= wb_dat_o;
          else         slave_dat <= mem[wb_adr_o[7:0]];
        end else begin
          wcnt <= wcnt + 1;
        end
      end else if (!wb_cyc_o) begin
        wcnt <= 0;
      end
    end
  end

  // Bus monitor: cycle counts, cycle starts, response starts, signal stability inside a cycle.
  int          cyc_total = 0, cyc_rises = 0, rsp_rises = 0, unstable_total = 0;
  logic        prev_cyc = 1'b0, prev_rsp = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_adr = '0, prev_dat = '0;

  always @(negedge wb_clk_i) begin
    if (wb_cyc_o) cyc_total++;
    if (wb_cyc_o && !prev_cyc) cyc_rises++;
    if (wb_cyc_o && prev_cyc &&
        (wb_adr_o !== prev_adr || wb_we_o !== prev_we || wb_dat_o !== prev_dat || wb_stb_o !== 1'b1))
      unstable_total++;
    if (rsp_valid && !prev_rsp) rsp_rises++;
    prev_cyc = wb_cyc_o;
    prev_rsp = rsp_valid;
    prev_adr = wb_adr_o;
    prev_we  = wb_we_o;
    prev_dat = wb_dat_o;
  end

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] ref_mem [0:255] = '{default: 16'h0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [15:0] adr, input logic [15:0] dat);
    int n = 0;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("cmd_ready_within_bound", 32'(n < 50), 32'd1);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp;
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge wb_clk_i);
      n++;
    end
    chk("rsp_valid_within_bound", 32'(n < 200), 32'd1);
  endtask

  task automatic take_rsp;
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
  endtask

  // One full transaction checked against the reference memory and the ack-latency rule.
  task automatic txn(input logic we, input logic [15:0] adr, input logic [15:0] dat, input int w);
    int c0, r0, s0, u0;
    logic [15:0] exp;
    slave_wait = w;
    c0 = cyc_total; r0 = rsp_rises; s0 = cyc_rises; u0 = unstable_total;
    exp = we ? 16'h0000 : ref_mem[adr[7:0]];
    if (we) ref_mem[adr[7:0]] = dat;
    issue(we, adr, dat);
    chk("wb_adr_o", 32'(wb_adr_o), 32'(adr));
    chk("wb_we_o", 32'(wb_we_o), 32'(we));
    if (we) chk("wb_dat_o", 32'(wb_dat_o), 32'(dat));
    wait_rsp;
    chk("rsp_dat", 32'(rsp_dat), 32'(exp));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    take_rsp;
    chk("rsp_valid_after_handshake", 32'(rsp_valid), 32'd0);
    chk("cyc_high_cycles", 32'(cyc_total - c0), 32'(w + 2));
    chk("cyc_starts", 32'(cyc_rises - s0), 32'd1);
    chk("responses", 32'(rsp_rises - r0), 32'd1);
    chk("bus_stable", 32'(unstable_total - u0), 32'd0);
    chk("wb_adr_o_held", 32'(wb_adr_o), 32'(adr));
  endtask

  initial begin
    int r0;
    logic [15:0] held;
    logic        we;
    logic [15:0] adr;

    // Reset state.
    repeat (3) @(negedge wb_clk_i);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_adr", 32'(wb_adr_o), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Write then read back with a one-cycle-ack slave.
    txn(1'b1, 16'h0001, 16'h0A5C, 0);
    txn(1'b0, 16'h0001, 16'h0000, 0);

    // Slow slave: ack seen 7 cycles after stb.
    txn(1'b0, 16'h0001, 16'h0000, 6);
    txn(1'b1, 16'h0005, 16'h1234, 6);

    // Response backpressure with the next command already waiting.
    slave_wait = 0;
    ref_mem[8'h22] = 16'hBEEF;
    issue(1'b1, 16'h0022, 16'hBEEF);
    wait_rsp;
    held = rsp_dat;
    chk("bp_first_rsp_dat", 32'(held), 32'd0);
    cmd_we = 1'b0; cmd_adr = 16'h0001; cmd_dat = 16'h0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_dat", 32'(rsp_dat), 32'(held));
      chk("bp_no_cycle", 32'(wb_cyc_o), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    chk("bp_ready_after_hs", 32'(cmd_ready), 32'd1);
    chk("bp_cyc_after_hs", 32'(wb_cyc_o), 32'd0);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    chk("bp_accept_next_cycle", 32'(wb_cyc_o), 32'd1);
    chk("bp_next_adr", 32'(wb_adr_o), 32'h0001);
    wait_rsp;
    chk("bp_second_rsp_dat", 32'(rsp_dat), 32'(ref_mem[8'h01]));
    take_rsp;

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 24; i++) begin
      we  = 1'($urandom_range(0, 1));
      adr = 16'($urandom_range(0, 65535)) & 16'hFF07;
      txn(we, adr, 16'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
    end

    // Stray ack while idle produces nothing.
    r0 = rsp_rises;
    stray_ack = 1'b1;
    @(negedge wb_clk_i);
    stray_ack = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    chk("stray_ack_no_rsp", 32'(rsp_rises - r0), 32'd0);
    chk("stray_ack_no_cyc", 32'(wb_cyc_o), 32'd0);
    txn(1'b0, 16'h0005, 16'h0000, 0);

`ifdef WBM_TIMEOUT_EN
    // Timeouts with no ack; error counter saturates.
    slave_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int c0;
      c0 = cyc_total;
      issue(1'b0, 16'h0040, 16'h0000);
      wait_rsp;
      chk("tmo_cyc_cycles", 32'(cyc_total - c0), 32'(TB_TMO));
      chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
      chk("tmo_rsp_dat", 32'(rsp_dat), 32'd0);
      chk("tmo_err_count", 32'(err_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      take_rsp;
    end
    slave_en = 1'b1;
    // Ack on the timeout edge wins.
    txn(1'b0, 16'h0001, 16'h0000, TB_TMO - 2);
    chk("coincident_err_count", 32'(err_count), 32'd255);
    // Ack one cycle too late: timeout, and the late ack is ignored.
    r0 = rsp_rises;
    slave_wait = TB_TMO - 1;
    issue(1'b0, 16'h0001, 16'h0000);
    wait_rsp;
    chk("late_ack_rsp_err", 32'(rsp_err), 32'd1);
    take_rsp;
    repeat (3) @(negedge wb_clk_i);
    chk("late_ack_one_rsp", 32'(rsp_rises - r0), 32'd1);
`endif

    // Reset mid-cycle drops the bus; a late ack afterwards is ignored.
    slave_en = 1'b0;
    issue(1'b0, 16'h0033, 16'h0000);
    @(negedge wb_clk_i);
    chk("mid_in_bus", 32'(wb_cyc_o), 32'd1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    wb_rst_i = 1'b0;
    r0 = rsp_rises;
    stray_ack = 1'b1;
    @(negedge wb_clk_i);
    stray_ack = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    chk("late_ack_after_rst", 32'(rsp_rises - r0), 32'd0);
    chk("ready_after_mid_rst", 32'(cmd_ready), 32'd1);
    slave_en = 1'b1;
    txn(1'b0, 16'h0005, 16'h0000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
